// File: rtl/bullet_pkg.sv
// bullet_pkg: screen geometry, bullet direction enum and the box-overlap test shared
// with the plane-collision logic.
package bullet_pkg;
  localparam int COORD_W = 11;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int BUL_SZ = 4;
  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;
  // Half-open boxes [c,c+w) x [r,r+h); evaluated wide so edge sums never wrap.
  function automatic logic box_overlap(
    input int unsigned ar, ac, ah, aw,
    input int unsigned br, bc, bh, bw
  );
    return (ac < bc + bw) && (bc < ac + aw) && (ar < br + bh) && (br < ar + ah);
  endfunction
endpackage

// File: rtl/bullet_slot_alloc.sv
// bullet_slot_alloc: lowest-index free slot priority encoder.
module bullet_slot_alloc #(
  parameter int SLOTS = 16,
  parameter int IW = 4
) (
  input  logic [SLOTS-1:0] free_i,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      idx_o = free_i[i] ? IW'(i) : idx_o;
      valid_o = valid_o | free_i[i];
    end
  end
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: per-player projectile pool with spawn, tick movement, target hits and pixel flag.
// Optional fire cooldown enabled by defining BULLET_POOL_COOLDOWN_EN.
module bullet_pool #(
  parameter int SLOTS = 16,
  parameter int COORD_W = bullet_pkg::COORD_W,
  parameter int SCREEN_W = bullet_pkg::SCREEN_W,
  parameter int BUL_SZ = bullet_pkg::BUL_SZ,
  parameter int STEP = 4,
  parameter bullet_pkg::dir_e DIR = bullet_pkg::DIR_RIGHT,
  parameter int TICK_DIV = 25_000_000,
  parameter int TGT_W = 40,
  parameter int TGT_H = 40,
  parameter int COOLDOWN = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic [COORD_W-1:0] spawn_row,
  input  logic [COORD_W-1:0] spawn_col,
  input  logic [COORD_W-1:0] tgt_row,
  input  logic [COORD_W-1:0] tgt_col,
  input  logic [COORD_W-1:0] pix_row,
  input  logic [COORD_W-1:0] pix_col,
  output logic               pix_on,
  output logic               hit,
  output logic [7:0]         hit_count,
  output logic [SLOTS-1:0]   alive,
  output logic               full,
  output logic               fire_drop
);
  import bullet_pkg::*;
  localparam int CW = COORD_W + 1;
  localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [COORD_W-1:0] row_q [SLOTS];
  logic [COORD_W-1:0] row_d [SLOTS];
  logic [COORD_W-1:0] col_q [SLOTS];
  logic [COORD_W-1:0] col_d [SLOTS];
  logic [SLOTS-1:0] alive_q, alive_d, hit_v, pix_v;
  logic [TW-1:0] cnt_q;
  logic [7:0] hc_q;
  logic hit_q, drop_q, pix_q, tick, accept, idx_ok;
  logic [IW-1:0] idx;

  bullet_slot_alloc #(.SLOTS(SLOTS), .IW(IW)) u_alloc (
    .free_i(~alive_q),
    .idx_o(idx),
    .valid_o(idx_ok)
  );

  assign tick = cnt_q == TW'(TICK_DIV - 1);

`ifdef BULLET_POOL_COOLDOWN_EN
  localparam int DW = $clog2(COOLDOWN + 1);
  logic [DW-1:0] cd_q;
  assign accept = fire & idx_ok & (cd_q == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) cd_q <= '0;
    else cd_q <= accept ? DW'(COOLDOWN) : (cd_q != '0 ? cd_q - 1'b1 : cd_q);
`else
  assign accept = fire & idx_ok;
`endif

  always_comb begin
    hit_v = '0;
    pix_v = '0;
    for (int i = 0; i < SLOTS; i++) begin
      hit_v[i] = alive_q[i] & box_overlap(32'(row_q[i]), 32'(col_q[i]), BUL_SZ, BUL_SZ,
                                          32'(tgt_row), 32'(tgt_col), TGT_H, TGT_W);
      pix_v[i] = alive_q[i] & box_overlap(32'(row_q[i]), 32'(col_q[i]), BUL_SZ, BUL_SZ,
                                          32'(pix_row), 32'(pix_col), 1, 1);
    end
  end

  // Collision wins over movement; allocation uses the pre-cycle mask so a slot
  // freed this cycle cannot be refilled until the next one.
  always_comb begin
    alive_d = alive_q;
    row_d = row_q;
    col_d = col_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (hit_v[i]) alive_d[i] = 1'b0;
      else if (tick && alive_q[i]) begin
        alive_d[i] = (DIR == DIR_RIGHT)
                   ? !(CW'(col_q[i]) + CW'(STEP) > CW'(SCREEN_W - BUL_SZ))
                   : !(CW'(col_q[i]) < CW'(STEP));
        col_d[i] = (DIR == DIR_RIGHT) ? col_q[i] + COORD_W'(STEP) : col_q[i] - COORD_W'(STEP);
      end
    end
    if (accept) begin
      alive_d[idx] = 1'b1;
      row_d[idx] = spawn_row;
      col_d[idx] = spawn_col;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alive_q <= '0;
      cnt_q <= '0;
      hc_q <= '0;
      hit_q <= 1'b0;
      drop_q <= 1'b0;
      pix_q <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      alive_q <= alive_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      hc_q <= (|hit_v && hc_q != 8'hFF) ? hc_q + 8'd1 : hc_q;
      hit_q <= |hit_v;
      drop_q <= fire & ~accept;
      pix_q <= |pix_v;
    end

  assign alive = alive_q;
  assign full = &alive_q;
  assign hit = hit_q;
  assign hit_count = hc_q;
  assign fire_drop = drop_q;
  assign pix_on = pix_q;
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed table, hand sequences and random traffic against a reference pool model.
module tb_bullet_pool;
  import bullet_pkg::*;
  logic clk = 1'b0, rst = 1'b1, fire = 1'b0;
  logic [10:0] spawn_row = '0, spawn_col = '0, tgt_row = 11'd1500, tgt_col = 11'd1500;
  logic [10:0] pix_row = 11'd2000, pix_col = 11'd2000;
  logic pix_o [2], hit_o [2], full_o [2], drop_o [2];
  logic [7:0] hc_o [2];
  logic [3:0] al_o [2];
  int n_chk = 0, n_fail = 0;
  int mrow [2][4], mcol [2][4], mhc [2], mcd [2], mcnt;
  bit mal [2][4], mhit [2], mdrop [2], mpix [2];

  always #5 clk = ~clk;

  bullet_pool #(.SLOTS(4), .DIR(DIR_RIGHT), .TICK_DIV(8), .COOLDOWN(10)) u_a (
    .clk(clk), .rst(rst), .fire(fire), .spawn_row(spawn_row), .spawn_col(spawn_col),
    .tgt_row(tgt_row), .tgt_col(tgt_col), .pix_row(pix_row), .pix_col(pix_col),
    .pix_on(pix_o[0]), .hit(hit_o[0]), .hit_count(hc_o[0]), .alive(al_o[0]),
    .full(full_o[0]), .fire_drop(drop_o[0]));
  bullet_pool #(.SLOTS(4), .DIR(DIR_LEFT), .TICK_DIV(8), .COOLDOWN(10)) u_b (
    .clk(clk), .rst(rst), .fire(fire), .spawn_row(spawn_row), .spawn_col(spawn_col),
    .tgt_row(tgt_row), .tgt_col(tgt_col), .pix_row(pix_row), .pix_col(pix_col),
    .pix_on(pix_o[1]), .hit(hit_o[1]), .hit_count(hc_o[1]), .alive(al_o[1]),
    .full(full_o[1]), .fire_drop(drop_o[1]));

  function automatic bit ovl(int r, int c, int h, int w, int tr, int tc, int th, int tw);
    return c < tc + tw && tc < c + w && r < tr + th && tr < r + h;
  endfunction

  function automatic int mask(int d);
    int v = 0;
    for (int s = 0; s < 4; s++) if (mal[d][s]) v |= 1 << s;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) begin mal[d][s] = 0; mrow[d][s] = 0; mcol[d][s] = 0; end
      mhc[d] = 0; mcd[d] = 0; mhit[d] = 0; mdrop[d] = 0; mpix[d] = 0;
    end
    mcnt = 0;
  endtask

  task automatic model_step();
    bit tick, pre [4], anyhit, pix, ok;
    int slot;
    tick = (mcnt % 8) == 7;
    for (int d = 0; d < 2; d++) begin
      pre = mal[d];
      anyhit = 0; pix = 0; slot = -1;
      for (int s = 0; s < 4; s++) if (pre[s]) begin
        if (ovl(mrow[d][s], mcol[d][s], 4, 4, int'(pix_row), int'(pix_col), 1, 1)) pix = 1;
        if (ovl(mrow[d][s], mcol[d][s], 4, 4, int'(tgt_row), int'(tgt_col), 40, 40)) begin
          mal[d][s] = 0; anyhit = 1;
        end else if (tick) begin
          if (d == 0) begin
            if (mcol[d][s] + 4 > 796) mal[d][s] = 0; else mcol[d][s] += 4;
          end else begin
            if (mcol[d][s] < 4) mal[d][s] = 0; else mcol[d][s] -= 4;
          end
        end
      end
      for (int s = 3; s >= 0; s--) if (!pre[s]) slot = s;
      ok = slot >= 0;
`ifdef BULLET_POOL_COOLDOWN_EN
      ok = ok && mcd[d] == 0;
      if (fire && ok) mcd[d] = 10; else if (mcd[d] > 0) mcd[d]--;
`endif
      mdrop[d] = fire && !ok;
      if (fire && ok) begin
        mal[d][slot] = 1; mrow[d][slot] = int'(spawn_row); mcol[d][slot] = int'(spawn_col);
      end
      mhit[d] = anyhit;
      if (anyhit && mhc[d] < 255) mhc[d]++;
      mpix[d] = pix;
    end
    mcnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("alive%0d", d), int'(al_o[d]), mask(d));
      chk($sformatf("full%0d", d), int'(full_o[d]), int'(mask(d) == 15));
      chk($sformatf("hit%0d", d), int'(hit_o[d]), int'(mhit[d]));
      chk($sformatf("hit_count%0d", d), int'(hc_o[d]), mhc[d]);
      chk($sformatf("fire_drop%0d", d), int'(drop_o[d]), int'(mdrop[d]));
      chk($sformatf("pix_on%0d", d), int'(pix_o[d]), int'(mpix[d]));
    end
  endtask

  task automatic do_reset();
    fire = 0;
    rst = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_alive%0d", d), int'(al_o[d]), 0);
      chk($sformatf("rst_hc%0d", d), int'(hc_o[d]), 0);
      chk($sformatf("rst_flags%0d", d), int'({pix_o[d], hit_o[d], full_o[d], drop_o[d]}), 0);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic shoot(int r, int c);
    spawn_row = 11'(r); spawn_col = 11'(c); fire = 1;
    step();
    fire = 0;
  endtask

  typedef struct { bit fire; int col; int ex_alive; bit ex_full; bit ex_drop; } vec_t;
  vec_t tv [6];

  initial begin
`ifdef BULLET_POOL_COOLDOWN_EN
    tv = '{'{1, 100, 1, 0, 0}, '{1, 110, 1, 0, 1}, '{1, 120, 1, 0, 1},
           '{1, 130, 1, 0, 1}, '{1, 140, 1, 0, 1}, '{0, 150, 1, 0, 0}};
`else
    tv = '{'{1, 100, 1, 0, 0}, '{1, 110, 3, 0, 0}, '{1, 120, 7, 0, 0},
           '{1, 130, 15, 1, 0}, '{1, 140, 15, 1, 1}, '{0, 150, 15, 1, 0}};
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // fill the pool from the table
    for (int i = 0; i < 6; i++) begin
      fire = tv[i].fire; spawn_row = 11'd20; spawn_col = 11'(tv[i].col);
      step();
      for (int d = 0; d < 2; d++) begin
        chk("tbl_alive", int'(al_o[d]), tv[i].ex_alive);
        chk("tbl_full", int'(full_o[d]), int'(tv[i].ex_full));
        chk("tbl_drop", int'(drop_o[d]), int'(tv[i].ex_drop));
      end
    end
    fire = 0;
    // movement: col 100 -> 104 -> 108 on successive ticks
    do_reset();
    shoot(10, 100);
    chk("t1_alive", int'(al_o[0]), 1);
    repeat (7) step();
    pix_row = 11'd10; pix_col = 11'd104;
    step();
    chk("t1_pix104", int'(pix_o[0]), 1);
    chk("t1_left_pix104", int'(pix_o[1]), 0);
    repeat (7) step();
    pix_col = 11'd108;
    step();
    chk("t1_pix108", int'(pix_o[0]), 1);
    pix_row = 11'd2000; pix_col = 11'd2000;
    // screen-edge frees
    do_reset();
    shoot(30, 793);
    repeat (7) step();
    chk("t3_r793", int'(al_o[0]), 0);
    chk("t3_l793", int'(al_o[1]), 1);
    do_reset();
    shoot(30, 3);
    repeat (7) step();
    chk("t3_r3", int'(al_o[0]), 1);
    chk("t3_l3", int'(al_o[1]), 0);
    do_reset();
    shoot(30, 792);
    shoot(40, 4);
    repeat (6) step();
    chk("t3_edge_r", int'(al_o[0]), 3);
    chk("t3_edge_l", int'(al_o[1]), 3);
    repeat (8) step();
    chk("t3_past_r", int'(al_o[0]), 2);
    chk("t3_past_l", int'(al_o[1]), 1);
    // target hit
    do_reset();
    tgt_row = 11'd100; tgt_col = 11'd700;
    shoot(110, 698);
    chk("t4_spawn", int'(al_o[0]), 1);
    step();
    chk("t4_hit", int'(hit_o[0]), 1);
    chk("t4_hc", int'(hc_o[0]), 1);
    chk("t4_freed", int'(al_o[0]), 0);
    step();
    chk("t4_hit_end", int'(hit_o[0]), 0);
    tgt_row = 11'd1500; tgt_col = 11'd1500;
`ifndef BULLET_POOL_COOLDOWN_EN
    // slot freed by edge on the tick is not reusable in the same cycle
    do_reset();
    shoot(40, 796);
    shoot(40, 100);
    shoot(40, 100);
    shoot(40, 100);
    repeat (3) step();
    shoot(40, 100);
    chk("t5_drop", int'(drop_o[0]), 1);
    chk("t5_alive", int'(al_o[0]), 14);
    step();
    shoot(40, 100);
    chk("t5_reuse", int'(al_o[0]), 15);
`else
    do_reset();
    shoot(60, 100);
    repeat (4) step();
    shoot(60, 100);
    chk("t7_drop", int'(drop_o[0]), 1);
    chk("t7_alive1", int'(al_o[0]), 1);
    repeat (6) step();
    shoot(60, 100);
    chk("t7_accept", int'(drop_o[0]), 0);
    chk("t7_alive2", int'(al_o[0]), 3);
`endif
    // pixel flag
    do_reset();
    shoot(50, 200);
    pix_row = 11'd52; pix_col = 11'd201;
    step();
    chk("t6_in", int'(pix_o[0]), 1);
    pix_row = 11'd54;
    step();
    chk("t6_below", int'(pix_o[0]), 0);
    pix_row = 11'd53; pix_col = 11'd204;
    step();
    chk("t6_right", int'(pix_o[0]), 0);
    pix_col = 11'd203;
    step();
    chk("t6_corner", int'(pix_o[0]), 1);
    // hit counter saturation, then asynchronous reset mid-flight
    tgt_row = 11'd100; tgt_col = 11'd700;
    spawn_row = 11'd110; spawn_col = 11'd698; fire = 1;
    repeat (3000) step();
    chk("sat_a", int'(hc_o[0]), 255);
    chk("sat_b", int'(hc_o[1]), 255);
    do_reset();
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      int s;
      if (n % 64 == 0) begin
        tgt_row = 11'($urandom_range(0, 300)); tgt_col = 11'($urandom_range(0, 800));
      end
      if (n % 1500 == 1499) do_reset();
      fire = $urandom_range(0, 3) == 0;
      spawn_row = 11'($urandom_range(0, 300)); spawn_col = 11'($urandom_range(0, 796));
      s = $urandom_range(0, 3);
      pix_row = 11'(mrow[0][s] + $urandom_range(0, 4));
      pix_col = 11'(mcol[0][s] + $urandom_range(0, 4));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
